pfb_mac_ctrl: RTL and testbench

PFB_MAC_CTRL -- requirements
Module: pfb_mac_ctrl

---
 rtl/pfb_ctrl_pkg.sv | 22 ++
 rtl/pfb_valid_pipe.sv | 33 +++
 rtl/pfb_mac_ctrl.sv | 141 ++++++++++++++
 tb/tb_pfb_mac_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfb_ctrl_pkg.sv
// pfb_ctrl_pkg: shared state encoding and width helpers for the PFB MAC controller
package pfb_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2
   } state_e;

   localparam int CFG_W = 16;

   // channel index width; a single-channel build still needs one address bit
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // coefficient RAM address width covering every tap of every channel
   function automatic int coef_aw(input int n, input int t);
      return $clog2(n * t);
   endfunction

endpackage

// File: rtl/pfb_valid_pipe.sv
// pfb_valid_pipe: ce-gated {valid,last} delay line that tracks beats through the MAC chain
module pfb_valid_pipe #(
   parameter int DEPTH = 28
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce,
   input  logic [1:0] din,
   output logic [1:0] dout,
   output logic       busy
);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] l_q;

   // shift one stage per enabled cycle; a held ce freezes every stage so no beat is lost or repeated
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q <= '0;
         l_q <= '0;
      end else if (ce) begin
         v_q <= {v_q[DEPTH-2:0], din[1]};
         l_q <= {l_q[DEPTH-2:0], din[0]};
      end
   end

   // tail stage is the chain output; busy covers every stage including the tail
   always_comb begin
      dout = {v_q[DEPTH-1], l_q[DEPTH-1]};
      busy = |v_q;
   end

endmodule

// File: rtl/pfb_mac_ctrl.sv
// pfb_mac_ctrl: sample sequencing, MAC clock-enable, output handshake and coefficient reload for a PFB
module pfb_mac_ctrl
   import pfb_ctrl_pkg::*;
#(
   parameter int NUM_CHANS = 64,
   parameter int NUM_TAPS  = 24,
   parameter int MAC_LAT   = 28,
   parameter int CHAN_W    = chan_w(NUM_CHANS),
   parameter int COEF_AW   = coef_aw(NUM_CHANS, NUM_TAPS)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               s_valid,
   output logic               s_ready,
   output logic [CHAN_W-1:0]  chan_addr,
   output logic               samp_we,
   output logic               ce,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               m_last,
   input  logic               load_req,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CFG_W-1:0]   cfg_data,
   output logic               coef_we,
   output logic [COEF_AW-1:0] coef_addr,
   output logic [CFG_W-1:0]   coef_wdata,
   output logic               load_busy
);

   localparam int NWORDS = NUM_CHANS * NUM_TAPS;

   state_e             state_q, state_d;
   logic               load_pend_q;
   logic [CHAN_W-1:0]  chan_q;
   logic [COEF_AW-1:0] idx_q;
   logic               coef_we_q;
   logic [COEF_AW-1:0] coef_addr_q;
   logic [CFG_W-1:0]   coef_wdata_q;
   logic               accept, cfg_fire, last_word, last_chan, pipe_busy;
   logic               enter_load, leave_load;
   logic [1:0]         pipe_out;

   // handshake qualifiers shared by the FSM and the datapath
   always_comb begin
      accept     = s_valid & s_ready;
      cfg_fire   = cfg_valid & cfg_ready;
      last_word  = idx_q == COEF_AW'(NWORDS - 1);
      last_chan  = chan_q == CHAN_W'(NUM_CHANS - 1);
      enter_load = (state_d == ST_LOAD) & (state_q != ST_LOAD);
      leave_load = (state_q == ST_LOAD) & (state_d == ST_RUN);
   end

   pfb_valid_pipe #(
      .DEPTH (MAC_LAT)
   ) u_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .din     ({accept, last_chan}),
      .dout    (pipe_out),
      .busy    (pipe_busy)
   );

   // chain output and the global enable that stalls everything behind an unaccepted beat
   always_comb begin
      m_valid = pipe_out[1];
      m_last  = pipe_out[0];
      ce      = ~m_valid | m_ready;
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_RUN;
      else          state_q <= state_d;
   end

   // next state: drain in-flight beats before rewriting coefficients under them
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (load_pend_q) state_d = ST_DRAIN;
         ST_DRAIN: if (!pipe_busy && !m_valid) state_d = ST_LOAD;
         ST_LOAD:  if (cfg_fire && last_word) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // FSM outputs; new samples stop as soon as a reload is pending
   always_comb begin
      s_ready   = ce & (state_q == ST_RUN) & ~load_pend_q;
      cfg_ready = state_q == ST_LOAD;
      load_busy = state_q != ST_RUN;
      samp_we   = accept;
   end

   // sticky reload request, honoured only while running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        load_pend_q <= 1'b0;
      else if (enter_load) load_pend_q <= 1'b0;
      else if (load_req && state_q == ST_RUN) load_pend_q <= 1'b1;
   end

   // channel counter steps per accepted sample and restarts after a reload
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        chan_q <= '0;
      else if (leave_load) chan_q <= '0;
      else if (accept)     chan_q <= chan_q + CHAN_W'(1);
   end

   // linear word index equals chan*NUM_TAPS+tap for a channel-major, tap-minor stream
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                idx_q <= '0;
      else if (state_q != ST_LOAD) idx_q <= '0;
      else if (cfg_fire)           idx_q <= last_word ? '0 : idx_q + COEF_AW'(1);
   end

   // registered coefficient RAM write port, one cycle behind the accepted word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         coef_we_q    <= 1'b0;
         coef_addr_q  <= '0;
         coef_wdata_q <= '0;
      end else begin
         coef_we_q <= cfg_fire;
         if (cfg_fire) begin
            coef_addr_q  <= idx_q;
            coef_wdata_q <= cfg_data;
         end
      end
   end

   // port drive from internal registers
   always_comb begin
      chan_addr  = chan_q;
      coef_we    = coef_we_q;
      coef_addr  = coef_addr_q;
      coef_wdata = coef_wdata_q;
   end

endmodule

// File: tb/tb_pfb_mac_ctrl.sv
// tb_pfb_mac_ctrl: directed scoreboard bench for the PFB MAC controller
module tb_pfb_mac_ctrl;

   localparam int NC  = 64;
   localparam int NT  = 24;
   localparam int LAT = 28;
   localparam int NW  = NC * NT;
   localparam int CW  = 6;
   localparam int AW  = 11;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          m_ready = 1'b1;
   logic          load_req = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [15:0]   cfg_data = '0;
   logic          s_ready, samp_we, ce, m_valid, m_last, cfg_ready, coef_we, load_busy;
   logic [CW-1:0] chan_addr;
   logic [AW-1:0] coef_addr;
   logic [15:0]   coef_wdata;

   int n_assert = 0;
   int n_fail = 0;
   int sb_chan[$];
   int sb_tag[$];
   logic [31:0] cq[$];
   int exp_chan = 0;
   int exp_idx = 0;
   int ce_cnt = 0;
   int n_beats = 0;
   int n_acc = 0;
   int n_last = 0;
   int n_cfg = 0;
   int b_chan, b_tag;
   logic [31:0] w;

   always #5 clk = ~clk;

   pfb_mac_ctrl #(.NUM_CHANS(NC), .NUM_TAPS(NT), .MAC_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
      .chan_addr(chan_addr), .samp_we(samp_we), .ce(ce), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .load_req(load_req),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .load_busy(load_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t = 0;
      while (sb_chan.size() != 0 && t < 300) begin
         tick();
         t++;
      end
      chk("drain_empty", sb_chan.size(), 0);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_coef_we"}, coef_we, 0);
      chk({tag, "_coef_addr"}, coef_addr, 0);
      chk({tag, "_coef_wdata"}, coef_wdata, 0);
      chk({tag, "_load_busy"}, load_busy, 0);
      chk({tag, "_cfg_ready"}, cfg_ready, 0);
      chk({tag, "_samp_we"}, samp_we, 0);
      chk({tag, "_ce"}, ce, 1);
      chk({tag, "_s_ready"}, s_ready, 1);
      chk({tag, "_chan_addr"}, chan_addr, 0);
   endtask

   // inputs change 1 time unit after posedge, so at negedge they equal what the next edge captures
   always @(negedge clk) begin
      if (reset_n) begin
         if (m_valid && m_ready) begin
            if (sb_chan.size() == 0) chk("spurious_beat", 1, 0);
            else begin
               b_chan = sb_chan.pop_front();
               b_tag = sb_tag.pop_front();
               chk("beat_last", m_last, b_chan == NC - 1);
               chk("beat_latency", ce_cnt - b_tag, LAT);
               n_beats++;
               if (m_last) n_last++;
            end
         end
         if (s_valid && s_ready) begin
            chk("accept_chan", chan_addr, exp_chan);
            chk("accept_samp_we", samp_we, 1);
            sb_chan.push_back(exp_chan);
            sb_tag.push_back(ce_cnt);
            exp_chan = (exp_chan + 1) % NC;
            n_acc++;
         end
         if (coef_we) begin
            if (cq.size() == 0) chk("spurious_coef_we", 1, 0);
            else begin
               w = cq.pop_front();
               chk("coef_addr", coef_addr, w[31:16]);
               chk("coef_wdata", coef_wdata, w[15:0]);
            end
         end
         if (cfg_valid && cfg_ready) begin
            cq.push_back({16'(exp_idx), cfg_data});
            exp_idx++;
            n_cfg++;
         end
         if (ce) ce_cnt++;
      end
   end

   initial begin
      int t, b0, l0, n;
      #1;
      tick();
      reset_vals("rst");
      reset_n = 1'b1;
      tick();
      reset_vals("post_rst");

      // cfg words offered while running must not be consumed
      cfg_valid = 1'b1;
      repeat (3) begin
         #2;
         chk("cfg_ready_run", cfg_ready, 0);
         chk("coef_we_run", coef_we, 0);
         tick();
      end
      cfg_valid = 1'b0;

      // continuous stream of three frames
      s_valid = 1'b1;
      repeat (3 * NC) tick();
      s_valid = 1'b0;
      drain();
      chk("stream_beats", n_beats, 3 * NC);
      chk("stream_lasts", n_last, 3);

      // output stall of ten cycles mid-stream
      s_valid = 1'b1;
      repeat (40) tick();
      m_ready = 1'b0;
      repeat (10) begin
         #2;
         chk("stall_ce", ce, 0);
         chk("stall_s_ready", s_ready, 0);
         tick();
      end
      m_ready = 1'b1;
      repeat (20) tick();
      s_valid = 1'b0;
      drain();
      chk("stall_beats", n_beats, n_acc);

      // 50% input duty cycle
      repeat (60) begin
         s_valid = ~s_valid;
         tick();
      end
      s_valid = 1'b0;
      drain();
      chk("toggle_beats", n_beats, n_acc);

      // position at channel 61, then 20 beats in flight with the request at channel 17
      n = (61 - exp_chan + NC) % NC;
      s_valid = 1'b1;
      repeat (n) tick();
      s_valid = 1'b0;
      drain();
      b0 = n_beats;
      s_valid = 1'b1;
      repeat (20) tick();
      s_valid = 1'b0;
      load_req = 1'b1;
      #2;
      chk("req_chan", chan_addr, 17);
      tick();
      load_req = 1'b0;
      #2;
      chk("pend_s_ready", s_ready, 0);
      tick();
      chk("drain_busy", load_busy, 1);
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      t = 0;
      while (!cfg_ready && t < 200) begin
         chk("drain_busy_wait", load_busy, 1);
         tick();
         t++;
      end
      chk("load_entered", cfg_ready, 1);
      chk("inflight_beats", n_beats - b0, 20);
      chk("inflight_sb_empty", sb_chan.size(), 0);

      // full coefficient load with gapped words and an ignored request
      exp_idx = 0;
      n_cfg = 0;
      t = 0;
      while (n_cfg < NW && t < 8000) begin
         chk("load_busy_load", load_busy, 1);
         cfg_valid = 1'($urandom_range(0, 1));
         cfg_data = 16'($urandom);
         load_req = (t == 50);
         tick();
         t++;
      end
      cfg_valid = 1'b0;
      load_req = 1'b0;
      chk("load_words", n_cfg, NW);
      #2;
      chk("load_done_busy", load_busy, 0);
      chk("load_done_chan", chan_addr, 0);
      chk("load_done_s_ready", s_ready, 1);
      exp_chan = 0;
      tick();
      chk("coef_q_empty", cq.size(), 0);
      repeat (5) begin
         chk("stay_run", load_busy, 0);
         tick();
      end

      // request together with the last channel, then reset partway through the load
      l0 = n_last;
      s_valid = 1'b1;
      repeat (NC - 1) tick();
      load_req = 1'b1;
      #2;
      chk("req_last_chan", chan_addr, NC - 1);
      tick();
      load_req = 1'b0;
      s_valid = 1'b0;
      t = 0;
      while (!cfg_ready && t < 200) begin
         tick();
         t++;
      end
      chk("load2_entered", cfg_ready, 1);
      chk("last_beat_out", n_last - l0, 1);
      chk("load2_sb_empty", sb_chan.size(), 0);
      exp_idx = 0;
      n_cfg = 0;
      t = 0;
      cfg_valid = 1'b1;
      while (n_cfg < 100 && t < 500) begin
         cfg_data = 16'($urandom);
         tick();
         t++;
      end
      chk("load2_words", n_cfg, 100);
      reset_n = 1'b0;
      #2;
      reset_vals("mid_load_rst");
      tick();
      cq.delete();
      exp_chan = 0;
      reset_n = 1'b1;
      repeat (20) begin
         #2;
         chk("after_rst_coef_we", coef_we, 0);
         chk("after_rst_cfg_ready", cfg_ready, 0);
         chk("after_rst_busy", load_busy, 0);
         tick();
      end
      cfg_valid = 1'b0;
      chk("final_sb_empty", sb_chan.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
